// File: rtl/bus_seq_pkg.sv
// Shared definitions for the single-bus microcode sequencer: opcodes, states,
// instruction field positions and the one-bus-driver check.
package bus_seq_pkg;

  localparam int OPC_LSB   = 12;
  localparam int ALUOP_LSB = 9;
  localparam int RD_LSB    = 7;
  localparam int RS_LSB    = 5;
  localparam int RT_LSB    = 3;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_ALU  = 4'd2;
  localparam logic [3:0] OP_RDPC = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MOV0 = 3'd1,
    S_ALU0 = 3'd2,
    S_ALU1 = 3'd3,
    S_ALU2 = 3'd4,
    S_ALU3 = 3'd5,
    S_PC0  = 3'd6
  } state_t;

  // ok is high when at most one bit of the driver-enable vector is set
  task automatic check_one_driver(input logic [15:0] drivers, output logic ok);
    ok = ((drivers & (drivers - 16'd1)) == 16'd0);
  endtask

endpackage

// File: rtl/bus_sequencer_if.sv
// Instruction handshake plus every datapath control line of the sequencer.
interface bus_sequencer_if #(
  parameter int INSTR_W = 16,
  parameter int NREG    = 4
);
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic [2:0]         opControl;
  logic               ALUin0;
  logic               ALUin1;
  logic               ALUOutLatch;
  logic               ALUOutEn;
  logic               PCOutEn;
  logic [NREG-1:0]    r_latch;
  logic [NREG-1:0]    r_out;
  logic               done;
  logic               err;
  logic [15:0]        retired;

  modport slave (
    input  instr, instr_valid,
    output instr_ready, opControl, ALUin0, ALUin1, ALUOutLatch, ALUOutEn,
           PCOutEn, r_latch, r_out, done, err, retired
  );

  modport master (
    output instr, instr_valid,
    input  instr_ready, opControl, ALUin0, ALUin1, ALUOutLatch, ALUOutEn,
           PCOutEn, r_latch, r_out, done, err, retired
  );
endinterface

// File: rtl/bus_seq_decode.sv
// Moore decode of sequencer state plus captured fields into bus controls.
module bus_seq_decode
  import bus_seq_pkg::*;
#(
  parameter int NREG = 4
) (
  input  state_t          state,
  input  logic [2:0]      aluop,
  input  logic [1:0]      rd,
  input  logic [1:0]      rs,
  input  logic [1:0]      rt,
  output logic [2:0]      opControl,
  output logic            ALUin0,
  output logic            ALUin1,
  output logic            ALUOutLatch,
  output logic            ALUOutEn,
  output logic            PCOutEn,
  output logic [NREG-1:0] r_latch,
  output logic [NREG-1:0] r_out
);
  logic [NREG-1:0] sel_rd, sel_rs, sel_rt;

  for (genvar i = 0; i < NREG; i++) begin : g_sel
    assign sel_rd[i] = (rd == 2'(i));
    assign sel_rs[i] = (rs == 2'(i));
    assign sel_rt[i] = (rt == 2'(i));
  end

  always_comb begin
    opControl   = 3'b000;
    ALUin0      = 1'b0;
    ALUin1      = 1'b0;
    ALUOutLatch = 1'b0;
    ALUOutEn    = 1'b0;
    PCOutEn     = 1'b0;
    r_latch     = '0;
    r_out       = '0;
    case (state)
      S_MOV0: begin r_out = sel_rs; r_latch = sel_rd; end
      S_ALU0: begin r_out = sel_rs; ALUin0 = 1'b1; opControl = aluop; end
      S_ALU1: begin r_out = sel_rt; ALUin1 = 1'b1; opControl = aluop; end
      S_ALU2: begin ALUOutLatch = 1'b1; opControl = aluop; end
      S_ALU3: begin ALUOutEn = 1'b1; r_latch = sel_rd; opControl = aluop; end
      S_PC0:  begin PCOutEn = 1'b1; r_latch = sel_rd; end
      default: ;
    endcase
  end
endmodule

// File: rtl/bus_sequencer.sv
// Microcode sequencer: accepts one instruction per handshake and walks the
// shared bus through its transfer steps, then pulses done (and err if illegal).
module bus_sequencer
  import bus_seq_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int NREG    = 4
) (
  input  logic           clk,
  input  logic           rst,
  bus_sequencer_if.slave bif
);
  state_t      state, state_nx;
  logic [2:0]  aluop_q;
  logic [1:0]  rd_q, rs_q, rt_q;
  logic        done_q, err_q, done_nx, err_nx;
  logic [15:0] retired_q;
  logic        accept;
  logic [3:0]  opcode;
  logic        unused_bits;

  assign opcode      = bif.instr[OPC_LSB +: 4];
  assign unused_bits = ^bif.instr[2:0];
  assign bif.instr_ready = (state == S_IDLE);
  assign accept      = bif.instr_valid && (state == S_IDLE);

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        case (opcode)
          OP_MOV:  state_nx = S_MOV0;
          OP_ALU:  state_nx = S_ALU0;
          OP_RDPC: state_nx = S_PC0;
          OP_NOP:  done_nx  = 1'b1;
          default: begin done_nx = 1'b1; err_nx = 1'b1; end
        endcase
      end
      S_ALU0: state_nx = S_ALU1;
      S_ALU1: state_nx = S_ALU2;
      S_ALU2: state_nx = S_ALU3;
      S_MOV0, S_PC0, S_ALU3: begin
        state_nx = S_IDLE;
        done_nx  = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      retired_q <= 16'd0;
      aluop_q   <= 3'd0;
      rd_q      <= 2'd0;
      rs_q      <= 2'd0;
      rt_q      <= 2'd0;
    end else begin
      state  <= state_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
      if (done_nx) retired_q <= retired_q + 16'd1;
      // fields are held here so the requester may change instr after accept
      if (accept) begin
        aluop_q <= bif.instr[ALUOP_LSB +: 3];
        rd_q    <= bif.instr[RD_LSB +: 2];
        rs_q    <= bif.instr[RS_LSB +: 2];
        rt_q    <= bif.instr[RT_LSB +: 2];
      end
    end
  end

  assign bif.done    = done_q;
  assign bif.err     = err_q;
  assign bif.retired = retired_q;

  bus_seq_decode #(.NREG(NREG)) u_decode (
    .state       (state),
    .aluop       (aluop_q),
    .rd          (rd_q),
    .rs          (rs_q),
    .rt          (rt_q),
    .opControl   (bif.opControl),
    .ALUin0      (bif.ALUin0),
    .ALUin1      (bif.ALUin1),
    .ALUOutLatch (bif.ALUOutLatch),
    .ALUOutEn    (bif.ALUOutEn),
    .PCOutEn     (bif.PCOutEn),
    .r_latch     (bif.r_latch),
    .r_out       (bif.r_out)
  );
endmodule

// File: tb/tb_bus_sequencer.sv
// Directed plus randomized bench for bus_sequencer against a per-cycle
// expected-transfer queue built from each accepted instruction.
module tb_bus_sequencer;
  import bus_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_sequencer_if #(.INSTR_W(16), .NREG(4)) bif ();

  bus_sequencer #(.INSTR_W(16), .NREG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif.slave)
  );

  typedef struct {
    logic [2:0] opc;
    logic       ain0, ain1, aol, aoe, pce;
    logic [3:0] rl, ro;
    logic       done, err, ready;
  } rec_t;

  rec_t        q[$];
  rec_t        cur;
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_ret  = 16'd0;
  int          n_acc    = 0;

  function automatic rec_t blank_rec(input logic ready);
    rec_t r;
    r.opc = 3'd0; r.ain0 = 1'b0; r.ain1 = 1'b0; r.aol = 1'b0; r.aoe = 1'b0;
    r.pce = 1'b0; r.rl = 4'd0; r.ro = 4'd0; r.done = 1'b0; r.err = 1'b0;
    r.ready = ready;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bus transfers of one instruction, one record per cycle, ending with done
  task automatic push_instr(input logic [15:0] ins);
    logic [3:0] op;
    logic [2:0] aop;
    rec_t r;
    op  = ins[15:12];
    aop = ins[11:9];
    if (op == 4'd1) begin
      r = blank_rec(1'b0); r.ro = 4'd1 << ins[6:5]; r.rl = 4'd1 << ins[8:7]; q.push_back(r);
    end else if (op == 4'd2) begin
      r = blank_rec(1'b0); r.opc = aop; r.ro = 4'd1 << ins[6:5]; r.ain0 = 1'b1; q.push_back(r);
      r = blank_rec(1'b0); r.opc = aop; r.ro = 4'd1 << ins[4:3]; r.ain1 = 1'b1; q.push_back(r);
      r = blank_rec(1'b0); r.opc = aop; r.aol = 1'b1; q.push_back(r);
      r = blank_rec(1'b0); r.opc = aop; r.aoe = 1'b1; r.rl = 4'd1 << ins[8:7]; q.push_back(r);
    end else if (op == 4'd3) begin
      r = blank_rec(1'b0); r.pce = 1'b1; r.rl = 4'd1 << ins[8:7]; q.push_back(r);
    end
    r = blank_rec(1'b1); r.done = 1'b1; r.err = (op > 4'd3); q.push_back(r);
  endtask

  task automatic step(input logic v, input logic [15:0] ins, input logic r, output logic acc);
    logic ok;
    @(negedge clk);
    bif.instr_valid = v;
    bif.instr       = ins;
    rst             = r;
    acc = !r && v && cur.ready;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      cur = blank_rec(1'b1);
      exp_ret = 16'd0;
      n_acc = 0;
    end else begin
      if (acc) begin push_instr(ins); n_acc++; end
      cur = (q.size() != 0) ? q.pop_front() : blank_rec(1'b1);
      if (cur.done) exp_ret = exp_ret + 16'd1;
    end
    chk("opControl",   32'(bif.opControl),   32'(cur.opc));
    chk("ALUin0",      32'(bif.ALUin0),      32'(cur.ain0));
    chk("ALUin1",      32'(bif.ALUin1),      32'(cur.ain1));
    chk("ALUOutLatch", 32'(bif.ALUOutLatch), 32'(cur.aol));
    chk("ALUOutEn",    32'(bif.ALUOutEn),    32'(cur.aoe));
    chk("PCOutEn",     32'(bif.PCOutEn),     32'(cur.pce));
    chk("r_latch",     32'(bif.r_latch),     32'(cur.rl));
    chk("r_out",       32'(bif.r_out),       32'(cur.ro));
    chk("done",        32'(bif.done),        32'(cur.done));
    chk("err",         32'(bif.err),         32'(cur.err));
    chk("instr_ready", 32'(bif.instr_ready), 32'(cur.ready));
    chk("retired",     32'(bif.retired),     32'(exp_ret));
    check_one_driver({10'd0, bif.ALUOutEn, bif.PCOutEn, bif.r_out}, ok);
    chk("one_driver",  32'(ok), 32'd1);
  endtask

  initial begin
    logic        a;
    logic        pending;
    logic [15:0] pins;
    logic [3:0]  op;
    int          cyc;
    cur = blank_rec(1'b1);
    bif.instr_valid = 1'b0;
    bif.instr = 16'h0000;

    // reset for two cycles
    step(1'b0, 16'h0, 1'b1, a);
    step(1'b0, 16'h0, 1'b1, a);
    chk("rst_retired", 32'(bif.retired), 32'd0);
    chk("rst_ready",   32'(bif.instr_ready), 32'd1);

    // ALU r0 <- r1 op3 r1
    step(1'b1, 16'h2628, 1'b0, a);
    chk("alu0_rout", 32'(bif.r_out), 32'h2);
    chk("alu0_in0",  32'(bif.ALUin0), 32'd1);
    chk("alu0_opc",  32'(bif.opControl), 32'd3);
    step(1'b0, 16'hFFFF, 1'b0, a);
    chk("alu1_rout", 32'(bif.r_out), 32'h2);
    chk("alu1_in1",  32'(bif.ALUin1), 32'd1);
    step(1'b0, 16'h0, 1'b0, a);
    chk("alu2_latch", 32'(bif.ALUOutLatch), 32'd1);
    step(1'b0, 16'h0, 1'b0, a);
    chk("alu3_en",   32'(bif.ALUOutEn), 32'd1);
    chk("alu3_rl",   32'(bif.r_latch), 32'h1);
    chk("alu3_opc",  32'(bif.opControl), 32'd3);
    step(1'b0, 16'h0, 1'b0, a);
    chk("alu_done",  32'(bif.done), 32'd1);
    chk("alu_ret",   32'(bif.retired), 32'd1);

    // MOV then RDPC offered back-to-back on done
    step(1'b0, 16'h0, 1'b1, a);
    step(1'b1, 16'h1120, 1'b0, a);
    chk("mov_rout", 32'(bif.r_out), 32'h2);
    chk("mov_rl",   32'(bif.r_latch), 32'h4);
    step(1'b1, 16'h3180, 1'b0, a);
    chk("mov_busy_acc", 32'(a), 32'd0);
    chk("mov_done", 32'(bif.done), 32'd1);
    step(1'b1, 16'h3180, 1'b0, a);
    chk("rdpc_acc_on_done", 32'(a), 32'd1);
    chk("rdpc_pce", 32'(bif.PCOutEn), 32'd1);
    chk("rdpc_rl",  32'(bif.r_latch), 32'h8);
    step(1'b0, 16'h0, 1'b0, a);
    chk("rdpc_done", 32'(bif.done), 32'd1);
    chk("pair_ret",  32'(bif.retired), 32'd2);

    // illegal opcode
    step(1'b1, 16'hF000, 1'b0, a);
    chk("ill_err",  32'(bif.err), 32'd1);
    chk("ill_done", 32'(bif.done), 32'd1);
    chk("ill_ret",  32'(bif.retired), 32'd3);
    step(1'b0, 16'h0, 1'b0, a);

    // reset while in ALU2
    step(1'b1, 16'h2E78, 1'b0, a);
    step(1'b0, 16'h0, 1'b0, a);
    step(1'b0, 16'h0, 1'b0, a);
    chk("pre_rst_alu2", 32'(bif.ALUOutLatch), 32'd1);
    step(1'b0, 16'h0, 1'b1, a);
    chk("midrst_ret",   32'(bif.retired), 32'd0);
    step(1'b0, 16'h0, 1'b0, a);
    chk("midrst_nodone", 32'(bif.done), 32'd0);

    // random stream, requester holds each instruction until accepted
    pending = 1'b0;
    pins = 16'h0;
    cyc = 0;
    while (n_acc < 2000 && cyc < 60000) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        op = 4'($urandom_range(0, 5));
        if (op > 4'd3) op = 4'($urandom_range(4, 15));
        pins = {op, 12'($urandom)};
        pending = 1'b1;
      end
      step(pending, pins, 1'b0, a);
      if (a) pending = 1'b0;
      cyc++;
    end
    chk("rand_budget", 32'(n_acc), 32'd2000);
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b0, a);
    chk("ret_vs_acc", 32'(bif.retired), 32'(n_acc[15:0]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Microcode control unit for the single-bus 16-bit datapath (ALU input/output registers, PC, general registers r0–r3, shared tri-state bus).
- Accepts one decoded instruction word per valid/ready handshake.
- Steps the bus through the required transfer cycles by driving every latch, output-enable and ALU opcode control.
- Guarantees at most one bus driver per cycle, and reports completion and illegal opcodes.

Parameters:
- INSTR_W, 16, instruction word width. Field positions below assume 16.
- NREG, 4, number of general registers. Sets the width of the one-hot r_latch/r_out buses.

Ports:
- clk input 1: system clock, rising edge.
- rst input 1: synchronous, active-high reset.
- instr input INSTR_W: instruction word.
- instr_valid input 1: instr is valid this cycle.
- instr_ready output 1: sequencer can accept instr. High only in IDLE.
- opControl output 3: ALU operation select.
- ALUin0 output 1: latch the bus into ALU input register 0.
- ALUin1 output 1: latch the bus into ALU input register 1.
- ALUOutLatch output 1: latch the ALU result into the ALU output register.
- ALUOutEn output 1: ALU output register drives the bus.
- PCOutEn output 1: PC drives the bus.
- r_latch output NREG: one-hot; r_latch[i] latches the bus into ri.
- r_out output NREG: one-hot; r_out[i] means ri drives the bus.
- done output 1: one-cycle pulse when an instruction retires.
- err output 1: one-cycle pulse, coincident with done, for an illegal opcode.
- retired output 16: count of retired instructions, including NOP and illegal.

Behaviour:
- Handshake and capture:
  - Accept when instr_valid && instr_ready at a rising edge.
  - Fields are captured into internal registers at acceptance. instr may change afterwards.
- Instruction fields:
  - [15:12] opcode.
  - [11:9] aluop.
  - [8:7] rd.
  - [6:5] rs.
  - [4:3] rt.
  - [2:0] ignored.
- Opcodes:
  - 0 NOP.
  - 1 MOV: rd <- rs.
  - 2 ALU: rd <- rs aluop rt.
  - 3 RDPC: rd <- PC.
  - 4–15 illegal.
- States: IDLE, MOV0, ALU0, ALU1, ALU2, ALU3, PC0. State register only; all control outputs decode combinationally from state plus captured fields (Moore).
- Per-state outputs (every control output not listed is 0):
  - IDLE: none.
  - MOV0: r_out[rs], r_latch[rd].
  - ALU0: r_out[rs], ALUin0.
  - ALU1: r_out[rt], ALUin1.
  - ALU2: ALUOutLatch.
  - ALU3: ALUOutEn, r_latch[rd].
  - PC0: PCOutEn, r_latch[rd].
  - opControl = captured aluop in ALU0–ALU3, else 3'b000.
- Transitions:
  - IDLE, on accept: opcode 1 -> MOV0; 2 -> ALU0; 3 -> PC0; 0 or illegal -> stay IDLE.
  - ALU0 -> ALU1 -> ALU2 -> ALU3 -> IDLE.
  - MOV0 and PC0 -> IDLE.
- done, err and retired:
  - done is registered. It pulses in the cycle after the final step. For NOP/illegal it pulses in the cycle after acceptance.
  - err is registered and pulses with done for illegal opcodes only.
  - retired increments on the same edge that sets done and wraps 16'hFFFF -> 0.
- Latency, with acceptance at edge N:
  - ALU: steps in cycles N+1..N+4, done at N+5.
  - MOV/RDPC: step at N+1, done at N+2.
  - NOP/illegal: done at N+1 with no control activity.
- Back-to-back: instr_ready is high in the same cycle done pulses, so a new instruction may be accepted there. Zero bubble beyond done.
- Bus exclusivity invariant: in every cycle, popcount({ALUOutEn, PCOutEn, r_out}) <= 1.
- rd == rs (MOV) or rd == rs/rt (ALU) is legal. Same-register out+latch in MOV0 re-latches the unchanged value.
- Reset:
  - Reset has priority over everything, including mid-instruction.
  - Next cycle: state IDLE, all control outputs 0, done=0, err=0, retired=0, instr_ready=1. The in-flight instruction is discarded without retiring.
- instr_valid while busy is ignored. The requester must hold it until accepted.

Decomposition:
- Shared package bus_seq_pkg holds:
  - Opcode constants OP_NOP/OP_MOV/OP_ALU/OP_RDPC.
  - State encoding constants.
  - Field bit positions.
  - The one-driver invariant checker as a reusable task.
- One natural sub-module: bus_seq_decode, the combinational state+fields -> control-vector decode, with a 2-to-4 one-hot register select. The FSM, capture registers, done/err and counter live in bus_sequencer.

Test Plan:
- Reset, then rst=1 for 2 cycles -> all controls 0, instr_ready=1, retired=0.
- ALU, instr=16'h2628 (aluop=3, rd=0, rs=1, rt=1) -> over four cycles:
  - r_out=0010 with ALUin0=1.
  - r_out=0010 with ALUin1=1.
  - ALUOutLatch=1.
  - ALUOutEn=1 with r_latch=0001.
  - opControl=3 throughout; done at N+5; retired=1.
- MOV then RDPC back-to-back, 16'h1120 (rd=2, rs=1) then 16'h3180 (rd=3) offered on done -> MOV step, done and second accept in the same cycle, PCOutEn with r_latch=1000, done; retired=2.
- Illegal opcode, instr=16'hF000 -> err=done=1 at N+1, no control asserted, retired increments.
- Reset asserted during ALU2 -> next cycle all controls 0, IDLE, no done, retired=0.
- Random instruction stream (2000 instructions) -> bus exclusivity invariant never violated; retired equals accepted count.
